// File: rtl/sha256_multiblock_control_if.sv
// Bus between the multi-block SHA-256 controller and its memories/datapath.
// The controller takes the master side; memories, datapath and bench take the slave side.
interface sha256_multiblock_control_if #(
   parameter int OUTPUT_LENGTH      = 8,
   parameter int MAX_MESSAGE_LENGTH = 119,
   parameter int NUMBER_OF_Ks       = 64,
   parameter int NUMBER_OF_Hs       = 8
);
   localparam int LEN_W = $clog2(MAX_MESSAGE_LENGTH) + 1;
   localparam int MA_W  = $clog2(MAX_MESSAGE_LENGTH);
   localparam int KA_W  = $clog2(NUMBER_OF_Ks);
   localparam int HA_W  = $clog2(NUMBER_OF_Hs);
   localparam int DA_W  = $clog2(OUTPUT_LENGTH);

   logic             xxx__dut__go;
   logic [LEN_W-1:0] xxx__dut__msg_length;
   logic [MA_W-1:0]  dut__msg__address;
   logic             dut__msg__enable;
   logic             dut__msg__write;
   logic [KA_W-1:0]  dut__kmem__address;
   logic             dut__kmem__enable;
   logic             dut__kmem__write;
   logic [HA_W-1:0]  dut__hmem__address;
   logic             dut__hmem__enable;
   logic             dut__hmem__write;
   logic [DA_W-1:0]  dut__dom__address;
   logic             dut__dom__enable;
   logic             dut__dom__write;
   logic             dut__xxx__finish;
   logic             busy;
   logic [1:0]       fill_sel;
   logic [7:0]       pad_byte;
   logic             byte_strobe;
   logic             W_start;
   logic             H_read;
   logic             H_iterate;
   logic             H_accum;
   logic             blk_last;

   modport master (
      input  xxx__dut__go, xxx__dut__msg_length,
      output dut__msg__address, dut__msg__enable, dut__msg__write,
      output dut__kmem__address, dut__kmem__enable, dut__kmem__write,
      output dut__hmem__address, dut__hmem__enable, dut__hmem__write,
      output dut__dom__address, dut__dom__enable, dut__dom__write,
      output dut__xxx__finish, busy, fill_sel, pad_byte, byte_strobe,
      output W_start, H_read, H_iterate, H_accum, blk_last
   );

   modport slave (
      output xxx__dut__go, xxx__dut__msg_length,
      input  dut__msg__address, dut__msg__enable, dut__msg__write,
      input  dut__kmem__address, dut__kmem__enable, dut__kmem__write,
      input  dut__hmem__address, dut__hmem__enable, dut__hmem__write,
      input  dut__dom__address, dut__dom__enable, dut__dom__write,
      input  dut__xxx__finish, busy, fill_sel, pad_byte, byte_strobe,
      input  W_start, H_read, H_iterate, H_accum, blk_last
   );
endinterface

// File: rtl/sha256_multiblock_control.sv
// Multi-block SHA-256 sequencer: loads H, streams message + padding bytes block by block,
// runs 64 compression rounds per block, accumulates, then writes the digest out.
module sha256_multiblock_control #(
   parameter int OUTPUT_LENGTH      = 8,
   parameter int MAX_MESSAGE_LENGTH = 119,
   parameter int NUMBER_OF_Ks       = 64,
   parameter int NUMBER_OF_Hs       = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   sha256_multiblock_control_if.master bus
);
   localparam int MAX_BLOCKS = (MAX_MESSAGE_LENGTH + 72) / 64;
   localparam int LEN_W      = $clog2(MAX_MESSAGE_LENGTH) + 1;
   localparam int MA_W       = $clog2(MAX_MESSAGE_LENGTH);
   localparam int KA_W       = $clog2(NUMBER_OF_Ks);
   localparam int HA_W       = $clog2(NUMBER_OF_Hs);
   localparam int DA_W       = $clog2(OUTPUT_LENGTH);
   localparam int NB_W       = $clog2(MAX_BLOCKS + 1);
   localparam int G_W        = $clog2(MAX_BLOCKS * 64) + 1;
   localparam int CNT_W      = $clog2(NUMBER_OF_Ks + NUMBER_OF_Hs + OUTPUT_LENGTH + 66);

   localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] HLOAD_LAST     = CNT_W'(NUMBER_OF_Hs);
   localparam logic [CNT_W-1:0] H_EN_LAST      = CNT_W'(NUMBER_OF_Hs - 1);
   localparam logic [CNT_W-1:0] MSG_LAST       = CNT_W'(64);
   localparam logic [CNT_W-1:0] MSG_ISSUE_LAST = CNT_W'(63);
   localparam logic [CNT_W-1:0] K_LAST         = CNT_W'(NUMBER_OF_Ks);
   localparam logic [CNT_W-1:0] K_EN_LAST      = CNT_W'(NUMBER_OF_Ks - 1);
   localparam logic [CNT_W-1:0] OUT_LAST       = CNT_W'(OUTPUT_LENGTH - 1);
   localparam logic [NB_W-1:0]  NB_ONE         = NB_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HLOAD = 3'd1,
      MSG   = 3'd2,
      ROUND = 3'd3,
      ACCUM = 3'd4,
      OUT   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [NB_W-1:0]  blk_r;
   logic [NB_W-1:0]  nb_r;
   logic [LEN_W-1:0] len_r;

   // Byte slot issued to msg memory last cycle; its output phase follows one cycle later.
   logic             slot_r;
   logic [5:0]       slot_j_r;
   logic [G_W-1:0]   slot_g_r;

   logic             msg_en_r;
   logic [MA_W-1:0]  msg_addr_r;
   logic             kmem_en_r;
   logic [KA_W-1:0]  kmem_addr_r;
   logic             hmem_en_r;
   logic [HA_W-1:0]  hmem_addr_r;
   logic             dom_en_r;
   logic [DA_W-1:0]  dom_addr_r;
   logic             finish_r;
   logic             busy_r;
   logic [1:0]       fill_sel_r;
   logic [7:0]       pad_byte_r;
   logic             byte_strobe_r;
   logic             w_start_r;
   logic             h_read_r;
   logic             h_iterate_r;
   logic             h_accum_r;
   logic             blk_last_r;

   logic             go_ok_s;
   logic [NB_W-1:0]  blk_next_s;
   logic             more_s;
   logic             issue_s;
   logic [5:0]       issue_j_s;
   logic [NB_W-1:0]  issue_blk_s;
   logic [G_W-1:0]   issue_g_s;
   logic             issue_hit_s;

   // Byte (63-j) of the 64-bit big-endian message bit length L*8.
   function automatic logic [7:0] len_byte(input logic [LEN_W-1:0] len, input logic [5:0] j);
      return 8'(64'({len, 3'b000}) >> {6'd63 - j, 3'b000});
   endfunction

   assign go_ok_s    = bus.xxx__dut__go && (bus.xxx__dut__msg_length <= LEN_W'(MAX_MESSAGE_LENGTH));
   assign blk_next_s = blk_r + NB_ONE;
   assign more_s     = (blk_next_s < nb_r);

   // Which message byte (if any) is requested in the coming cycle.
   always_comb begin
      issue_s     = 1'b0;
      issue_j_s   = 6'd0;
      issue_blk_s = blk_r;
      case (state_r)
         HLOAD: begin
            if (cnt_r == HLOAD_LAST) begin
               issue_s     = 1'b1;
               issue_blk_s = '0;
            end else begin
               issue_s = 1'b0;
            end
         end
         MSG: begin
            if (cnt_r < MSG_ISSUE_LAST) begin
               issue_s   = 1'b1;
               issue_j_s = 6'(cnt_r + CNT_ONE);
            end else begin
               issue_s = 1'b0;
            end
         end
         ACCUM: begin
            if (more_s) begin
               issue_s     = 1'b1;
               issue_blk_s = blk_next_s;
            end else begin
               issue_s = 1'b0;
            end
         end
         default: begin
            issue_s = 1'b0;
         end
      endcase
      issue_g_s   = G_W'({issue_blk_s, issue_j_s});
      issue_hit_s = issue_s && (issue_g_s < G_W'(len_r));
   end

   // Sequencer: state, counters and every registered output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         blk_r         <= '0;
         nb_r          <= '0;
         len_r         <= '0;
         slot_r        <= 1'b0;
         slot_j_r      <= 6'd0;
         slot_g_r      <= '0;
         msg_en_r      <= 1'b0;
         msg_addr_r    <= '0;
         kmem_en_r     <= 1'b0;
         kmem_addr_r   <= '0;
         hmem_en_r     <= 1'b0;
         hmem_addr_r   <= '0;
         dom_en_r      <= 1'b0;
         dom_addr_r    <= '0;
         finish_r      <= 1'b0;
         busy_r        <= 1'b0;
         fill_sel_r    <= 2'b00;
         pad_byte_r    <= 8'h00;
         byte_strobe_r <= 1'b0;
         w_start_r     <= 1'b0;
         h_read_r      <= 1'b0;
         h_iterate_r   <= 1'b0;
         h_accum_r     <= 1'b0;
         blk_last_r    <= 1'b0;
      end else begin
         h_read_r      <= hmem_en_r;
         h_iterate_r   <= kmem_en_r;
         byte_strobe_r <= slot_r;
         w_start_r     <= slot_r && (slot_j_r == 6'd0);
         slot_r        <= issue_s;
         slot_j_r      <= issue_j_s;
         slot_g_r      <= issue_g_s;
         msg_en_r      <= issue_hit_s;
         msg_addr_r    <= issue_hit_s ? MA_W'(issue_g_s) : '0;

         if (slot_r && (slot_g_r >= G_W'(len_r))) begin
            fill_sel_r <= 2'b01;
            if (slot_g_r == G_W'(len_r)) begin
               pad_byte_r <= 8'h80;
            end else if (blk_last_r && (slot_j_r >= 6'd56)) begin
               pad_byte_r <= len_byte(len_r, slot_j_r);
            end else begin
               pad_byte_r <= 8'h00;
            end
         end else begin
            fill_sel_r <= 2'b00;
            pad_byte_r <= 8'h00;
         end

         case (state_r)
            IDLE: begin
               if (go_ok_s) begin
                  len_r       <= bus.xxx__dut__msg_length;
                  nb_r        <= NB_W'(((LEN_W+2)'(bus.xxx__dut__msg_length) + (LEN_W+2)'(72)) >> 6);
                  blk_r       <= '0;
                  cnt_r       <= '0;
                  busy_r      <= 1'b1;
                  hmem_en_r   <= 1'b1;
                  hmem_addr_r <= '0;
                  state_r     <= HLOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            HLOAD: begin
               if (cnt_r < H_EN_LAST) begin
                  hmem_en_r   <= 1'b1;
                  hmem_addr_r <= HA_W'(cnt_r + CNT_ONE);
               end else begin
                  hmem_en_r   <= 1'b0;
                  hmem_addr_r <= '0;
               end
               if (cnt_r == HLOAD_LAST) begin
                  cnt_r      <= '0;
                  blk_last_r <= (nb_r == NB_ONE);
                  state_r    <= MSG;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            MSG: begin
               if (cnt_r == MSG_LAST) begin
                  cnt_r       <= '0;
                  kmem_en_r   <= 1'b1;
                  kmem_addr_r <= '0;
                  state_r     <= ROUND;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ROUND: begin
               if (cnt_r < K_EN_LAST) begin
                  kmem_en_r   <= 1'b1;
                  kmem_addr_r <= KA_W'(cnt_r + CNT_ONE);
               end else begin
                  kmem_en_r   <= 1'b0;
                  kmem_addr_r <= '0;
               end
               if (cnt_r == K_LAST) begin
                  cnt_r     <= '0;
                  h_accum_r <= 1'b1;
                  state_r   <= ACCUM;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ACCUM: begin
               h_accum_r <= 1'b0;
               cnt_r     <= '0;
               if (more_s) begin
                  blk_r      <= blk_next_s;
                  blk_last_r <= (blk_next_s == (nb_r - NB_ONE));
                  state_r    <= MSG;
               end else begin
                  blk_last_r <= 1'b0;
                  dom_en_r   <= 1'b1;
                  dom_addr_r <= '0;
                  state_r    <= OUT;
               end
            end
            OUT: begin
               if (cnt_r == OUT_LAST) begin
                  cnt_r      <= '0;
                  dom_en_r   <= 1'b0;
                  dom_addr_r <= '0;
                  finish_r   <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  cnt_r      <= cnt_r + CNT_ONE;
                  dom_addr_r <= DA_W'(cnt_r + CNT_ONE);
               end
            end
            DONE: begin
               finish_r <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               cnt_r    <= '0;
               finish_r <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign bus.dut__msg__address  = msg_addr_r;
   assign bus.dut__msg__enable   = msg_en_r;
   assign bus.dut__msg__write    = 1'b0;
   assign bus.dut__kmem__address = kmem_addr_r;
   assign bus.dut__kmem__enable  = kmem_en_r;
   assign bus.dut__kmem__write   = 1'b0;
   assign bus.dut__hmem__address = hmem_addr_r;
   assign bus.dut__hmem__enable  = hmem_en_r;
   assign bus.dut__hmem__write   = 1'b0;
   assign bus.dut__dom__address  = dom_addr_r;
   assign bus.dut__dom__enable   = dom_en_r;
   assign bus.dut__dom__write    = dom_en_r;
   assign bus.dut__xxx__finish   = finish_r;
   assign bus.busy               = busy_r;
   assign bus.fill_sel           = fill_sel_r;
   assign bus.pad_byte           = pad_byte_r;
   assign bus.byte_strobe        = byte_strobe_r;
   assign bus.W_start            = w_start_r;
   assign bus.H_read             = h_read_r;
   assign bus.H_iterate          = h_iterate_r;
   assign bus.H_accum            = h_accum_r;
   assign bus.blk_last           = blk_last_r;
endmodule

// File: tb/tb_sha256_multiblock_control.sv
// Bench for sha256_multiblock_control: every cycle's outputs are compared against a
// timeline model derived from the block/round schedule and the padding rules.
module tb_sha256_multiblock_control;
   localparam int MAXL = 119;

   logic clk = 1'b0;
   logic reset_n;
   int   vectors = 0;
   int   miscompares = 0;

   sha256_multiblock_control_if bus ();

   sha256_multiblock_control dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] observe();
      return {19'd0, bus.busy, bus.dut__xxx__finish,
              bus.dut__msg__enable, bus.dut__msg__address,
              bus.dut__kmem__enable, bus.dut__kmem__address,
              bus.dut__hmem__enable, bus.dut__hmem__address,
              bus.dut__dom__enable, bus.dut__dom__write, bus.dut__dom__address,
              bus.byte_strobe, bus.fill_sel, bus.pad_byte,
              bus.W_start, bus.H_read, bus.H_iterate, bus.H_accum, bus.blk_last,
              bus.dut__msg__write, bus.dut__kmem__write, bus.dut__hmem__write};
   endfunction

   // Expected outputs in cycle c after the go-sampling edge (c = 0 is the first busy cycle).
   function automatic logic [63:0] expect_at(input int len, input int c);
      int nb, total, base_out, b, r, g, j, t;
      logic       busy_e = 1'b0, fin = 1'b0, me = 1'b0, ke = 1'b0, he = 1'b0;
      logic       de = 1'b0, bs = 1'b0, ws = 1'b0, hr = 1'b0, hi = 1'b0, hac = 1'b0, bl = 1'b0;
      logic [6:0] ma = 7'd0;
      logic [5:0] ka = 6'd0;
      logic [2:0] ha = 3'd0, da = 3'd0;
      logic [1:0] fs = 2'b00;
      logic [7:0] pb = 8'h00;
      logic [63:0] lbits;
      nb       = (len + 72) / 64;
      base_out = 9 + 131 * nb;
      total    = base_out + 8;
      lbits    = 64'(len) * 64'd8;
      busy_e   = (c >= 0) && (c <= total);
      fin      = (c == total);
      if (c >= 0 && c < 8) begin
         he = 1'b1;
         ha = 3'(c);
      end
      hr = (c >= 1) && (c <= 8);
      if (c >= 9 && c < base_out) begin
         b  = (c - 9) / 131;
         r  = (c - 9) % 131;
         bl = (b == nb - 1);
         if (r < 64) begin
            g = b * 64 + r;
            if (g < len) begin
               me = 1'b1;
               ma = 7'(g);
            end
         end
         if (r >= 1 && r <= 64) begin
            j  = r - 1;
            g  = b * 64 + j;
            bs = 1'b1;
            ws = (j == 0);
            if (g >= len) begin
               fs = 2'b01;
               if (g == len) pb = 8'h80;
               else if (b == nb - 1 && j >= 56) pb = 8'(lbits >> (8 * (63 - j)));
               else pb = 8'h00;
            end
         end
         if (r >= 65 && r <= 129) begin
            t = r - 65;
            if (t < 64) begin
               ke = 1'b1;
               ka = 6'(t);
            end
            hi = (t >= 1);
         end
         hac = (r == 130);
      end
      if (c >= base_out && c < base_out + 8) begin
         de = 1'b1;
         da = 3'(c - base_out);
      end
      return {19'd0, busy_e, fin, me, ma, ke, ka, he, ha, de, de, da,
              bs, fs, pb, ws, hr, hi, hac, bl, 3'b000};
   endfunction

   // One message; optional re-pulse of go while busy and optional async reset abort.
   task automatic run_txn(input int len, input int busy_go_c, input int abort_c);
      int total, fin_c;
      total = 9 + 131 * ((len + 72) / 64) + 8;
      fin_c = -1;
      @(negedge clk);
      bus.xxx__dut__go         = 1'b1;
      bus.xxx__dut__msg_length = 8'(len);
      @(negedge clk);
      bus.xxx__dut__go = 1'b0;
      for (int c = 0; c <= total + 3; c++) begin
         if (c == abort_c) begin
            #2 reset_n = 1'b0;
            #1 check("rst_async", observe(), 64'd0);
            repeat (2) begin
               @(negedge clk);
               check("rst_hold", observe(), 64'd0);
            end
            reset_n = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check("rst_idle", observe(), 64'd0);
            end
            return;
         end
         check($sformatf("L%0d_c%0d", len, c), observe(), expect_at(len, c));
         if (bus.dut__xxx__finish === 1'b1 && fin_c < 0) fin_c = c;
         if (c == busy_go_c) begin
            bus.xxx__dut__go         = 1'b1;
            bus.xxx__dut__msg_length = 8'($urandom_range(0, MAXL));
         end else begin
            bus.xxx__dut__go = 1'b0;
         end
         @(negedge clk);
      end
      check($sformatf("latency_L%0d", len), 64'(fin_c), 64'(total));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.xxx__dut__go         = 1'b0;
      bus.xxx__dut__msg_length = 8'd0;
      reset_n                  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset", observe(), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle", observe(), 64'd0);

      run_txn(3, -1, -1);
      run_txn(55, -1, -1);
      run_txn(56, 200, -1);
      run_txn(0, 30, -1);
      run_txn(MAXL, -1, -1);

      @(negedge clk);
      bus.xxx__dut__go         = 1'b1;
      bus.xxx__dut__msg_length = 8'(MAXL + 1);
      repeat (4) begin
         @(negedge clk);
         bus.xxx__dut__go = 1'b0;
         check("oversize_go", observe(), 64'd0);
      end

      run_txn(100, -1, 9 + 131 + 65 + 20);
      run_txn(3, -1, -1);

      for (int i = 0; i < 6; i++) begin
         run_txn(int'($urandom_range(0, MAXL)), int'($urandom_range(0, 140)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
